// File: rtl/operand_issue_buffer_if.sv
// operand_issue_buffer_if
//  Handshake and payload bundle between decode/register-read (master) and the
//  operand issue buffer (slave).
//  Upstream side : InputValid/InputReady plus the raw instruction fields and operands.
//  Downstream side: OutputValid/OutputReady plus the head entry's controls, formed
//                   immediate and operands.
interface operand_issue_buffer_if #(
    parameter int DATABITWIDTH    = 16,
    parameter int REGADDRBITWIDTH = 4,
    parameter int OPCODEBITWIDTH  = 4
);
    logic                          InputValid;
    logic                          InputReady;
    logic [DATABITWIDTH/2-1:0]     ImmFieldIn;
    logic                          ImmediateEnIn;
    logic                          UpperImmediateEnIn;
    logic                          SignExtendEnIn;
    logic [OPCODEBITWIDTH-1:0]     OpcodeIn;
    logic [REGADDRBITWIDTH-1:0]    DestRegIn;
    logic [DATABITWIDTH-1:0]       ADataIn;
    logic [DATABITWIDTH-1:0]       BDataIn;

    logic                          OutputValid;
    logic                          OutputReady;
    logic                          ImmediateEn;
    logic                          UpperImmediateEn;
    logic [DATABITWIDTH-1:0]       ImmediateOut;
    logic [OPCODEBITWIDTH-1:0]     OpcodeOut;
    logic [REGADDRBITWIDTH-1:0]    DestRegOut;
    logic [DATABITWIDTH-1:0]       ADataOut;
    logic [DATABITWIDTH-1:0]       BDataOut;

    modport master (
        output InputValid, ImmFieldIn, ImmediateEnIn, UpperImmediateEnIn, SignExtendEnIn,
               OpcodeIn, DestRegIn, ADataIn, BDataIn, OutputReady,
        input  InputReady, OutputValid, ImmediateEn, UpperImmediateEn, ImmediateOut,
               OpcodeOut, DestRegOut, ADataOut, BDataOut
    );

    modport slave (
        input  InputValid, ImmFieldIn, ImmediateEnIn, UpperImmediateEnIn, SignExtendEnIn,
               OpcodeIn, DestRegIn, ADataIn, BDataIn, OutputReady,
        output InputReady, OutputValid, ImmediateEn, UpperImmediateEn, ImmediateOut,
               OpcodeOut, DestRegOut, ADataOut, BDataOut
    );
endinterface

// File: rtl/operand_issue_buffer.sv
// operand_issue_buffer
//  Two-entry skid-buffered stage between decode/register-read and the execute-side
//  B-operand immediate mux. Forms the full-width immediate from the half-width
//  instruction field and registers it together with the decoded controls and A/B
//  operands. Full throughput when downstream is not stalling.
// Ports
//  clk     : rising-edge clock
//  clear   : synchronous active-high reset (also zeroes all payload outputs)
//  FlushEn : drop every buffered entry and any entry offered this cycle
//  bus     : slave side of operand_issue_buffer_if (input handshake + fields,
//            output handshake + head entry)
module operand_issue_buffer #(
    parameter int DATABITWIDTH    = 16,
    parameter int REGADDRBITWIDTH = 4,
    parameter int OPCODEBITWIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  FlushEn,
    operand_issue_buffer_if.slave bus
);
    localparam int IMMBITWIDTH = DATABITWIDTH / 2;

    localparam logic [1:0] STATEEMPTY = 2'd0;
    localparam logic [1:0] STATEONE   = 2'd1;
    localparam logic [1:0] STATEFULL  = 2'd2;

    typedef struct packed {
        logic                       immediateEn;
        logic                       upperImmediateEn;
        logic [DATABITWIDTH-1:0]    immediate;
        logic [OPCODEBITWIDTH-1:0]  opcode;
        logic [REGADDRBITWIDTH-1:0] destReg;
        logic [DATABITWIDTH-1:0]    aData;
        logic [DATABITWIDTH-1:0]    bData;
    } entry_t;

    // Upper placement wins over sign extension; otherwise zero-extend.
    function automatic logic signed [DATABITWIDTH-1:0] formImmediate(
        input logic [IMMBITWIDTH-1:0] field,
        input logic                   upper,
        input logic                   signExtend
    );
        logic signed [IMMBITWIDTH-1:0] signedField;
        signedField = field;
        if (upper)
            return {field, {IMMBITWIDTH{1'b0}}};
        else if (signExtend)
            return {{(DATABITWIDTH-IMMBITWIDTH){signedField[IMMBITWIDTH-1]}}, signedField};
        else
            return {{(DATABITWIDTH-IMMBITWIDTH){1'b0}}, field};
    endfunction

    logic [1:0] state;
    logic [1:0] nextState;
    entry_t     entry_p0;
    entry_t     headEntry_p1;
    entry_t     skidEntry_p1;
    logic       inputReady;
    logic       outputValid;
    logic       inXfer;
    logic       outXfer;
    logic       loadHead;
    logic       headFromSkid;
    logic       loadSkid;

    // Stage p0: immediate formation on the incoming fields
    always_comb begin
        entry_p0.immediateEn      = bus.ImmediateEnIn;
        entry_p0.upperImmediateEn = bus.UpperImmediateEnIn;
        entry_p0.immediate        = formImmediate(bus.ImmFieldIn, bus.UpperImmediateEnIn,
                                                  bus.SignExtendEnIn);
        entry_p0.opcode           = bus.OpcodeIn;
        entry_p0.destReg          = bus.DestRegIn;
        entry_p0.aData            = bus.ADataIn;
        entry_p0.bData            = bus.BDataIn;
    end

    // Ready depends only on stored state (and clear), never on OutputReady.
    assign inputReady  = (state != STATEFULL) && !clear;
    assign outputValid = (state != STATEEMPTY);
    assign inXfer      = bus.InputValid && inputReady;
    assign outXfer     = outputValid && bus.OutputReady;

    always_comb begin
        nextState    = state;
        loadHead     = 1'b0;
        headFromSkid = 1'b0;
        loadSkid     = 1'b0;
        case (state)
            STATEEMPTY: begin
                if (inXfer) begin
                    nextState = STATEONE;
                    loadHead  = 1'b1;
                end
            end
            STATEONE: begin
                if (inXfer && outXfer) begin
                    loadHead = 1'b1;
                end else if (inXfer) begin
                    nextState = STATEFULL;
                    loadSkid  = 1'b1;
                end else if (outXfer) begin
                    nextState = STATEEMPTY;
                end
            end
            STATEFULL: begin
                if (outXfer) begin
                    nextState    = STATEONE;
                    loadHead     = 1'b1;
                    headFromSkid = 1'b1;
                end
            end
            default: nextState = STATEEMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear)
            state <= STATEEMPTY;
        else if (FlushEn)
            state <= STATEEMPTY;
        else
            state <= nextState;
    end

    // Stage p1: head/skid storage. Cleared so payload never shows X after clear;
    // a flush only retires entries and leaves the data untouched.
    always_ff @(posedge clk) begin
        if (clear) begin
            headEntry_p1 <= '0;
            skidEntry_p1 <= '0;
        end else if (!FlushEn) begin
            if (loadHead)
                headEntry_p1 <= headFromSkid ? skidEntry_p1 : entry_p0;
            if (loadSkid)
                skidEntry_p1 <= entry_p0;
        end
    end

    assign bus.InputReady       = inputReady;
    assign bus.OutputValid      = outputValid;
    assign bus.ImmediateEn      = headEntry_p1.immediateEn;
    assign bus.UpperImmediateEn = headEntry_p1.upperImmediateEn;
    assign bus.ImmediateOut     = headEntry_p1.immediate;
    assign bus.OpcodeOut        = headEntry_p1.opcode;
    assign bus.DestRegOut       = headEntry_p1.destReg;
    assign bus.ADataOut         = headEntry_p1.aData;
    assign bus.BDataOut         = headEntry_p1.bData;
endmodule

// File: tb/tb_operand_issue_buffer.sv
module tb_operand_issue_buffer;
    logic clk;
    logic clear;
    logic flushEn;
    int   vectors;
    int   miscompares;

    operand_issue_buffer_if #(.DATABITWIDTH(16), .REGADDRBITWIDTH(4), .OPCODEBITWIDTH(4)) bus ();

    operand_issue_buffer #(.DATABITWIDTH(16), .REGADDRBITWIDTH(4), .OPCODEBITWIDTH(4)) dut (
        .clk    (clk),
        .clear  (clear),
        .FlushEn(flushEn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        immEn;
        logic        upper;
        logic [15:0] imm;
        logic [3:0]  opc;
        logic [3:0]  dest;
        logic [15:0] a;
        logic [15:0] b;
    } exp_t;

    exp_t model[$];

    // Reference immediate built from plain arithmetic on the field value.
    function automatic logic [15:0] refImm(input logic [7:0] field, input logic up, input logic se);
        int v;
        v = int'(field);
        if (up) v = v * 256;
        else if (se && v >= 128) v = v - 256;
        return 16'(v);
    endfunction

    task automatic drive(input logic v, input logic [7:0] imm, input logic ie, input logic up,
                         input logic se, input logic [3:0] opc, input logic [3:0] dest,
                         input logic [15:0] a, input logic [15:0] b);
        bus.InputValid         = v;
        bus.ImmFieldIn         = imm;
        bus.ImmediateEnIn      = ie;
        bus.UpperImmediateEnIn = up;
        bus.SignExtendEnIn     = se;
        bus.OpcodeIn           = opc;
        bus.DestRegIn          = dest;
        bus.ADataIn            = a;
        bus.BDataIn            = b;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        vectors++; if (bus.InputReady !== 1'b0) begin miscompares++; $display("FAIL reset_ready_during_clear got %b exp 0", bus.InputReady); end
        vectors++; if (bus.OutputValid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b exp 0", bus.OutputValid); end
        vectors++; if ({bus.ImmediateOut, bus.ADataOut, bus.BDataOut, bus.OpcodeOut, bus.DestRegOut, bus.ImmediateEn, bus.UpperImmediateEn} !== 58'd0) begin
            miscompares++; $display("FAIL reset_payload got imm=%h a=%h b=%h exp all zero", bus.ImmediateOut, bus.ADataOut, bus.BDataOut); end
        clear = 1'b0;
        @(negedge clk);
        vectors++; if (bus.InputReady !== 1'b1) begin miscompares++; $display("FAIL reset_ready_after got %b exp 1", bus.InputReady); end
    endtask

    task automatic test_sign_extend();
        bus.OutputReady = 1'b0;
        drive(1'b1, 8'hF0, 1'b1, 1'b0, 1'b1, 4'h3, 4'h5, 16'h1111, 16'h2222);
        @(negedge clk);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 16'h0, 16'h0);
        vectors++; if (bus.OutputValid !== 1'b1) begin miscompares++; $display("FAIL sext_valid got %b exp 1", bus.OutputValid); end
        vectors++; if (bus.ImmediateOut !== 16'hFFF0) begin miscompares++; $display("FAIL sext_imm got %h exp fff0", bus.ImmediateOut); end
        vectors++; if ({bus.ImmediateEn, bus.UpperImmediateEn, bus.OpcodeOut, bus.DestRegOut} !== {1'b1, 1'b0, 4'h3, 4'h5}) begin
            miscompares++; $display("FAIL sext_ctrl got ie=%b up=%b op=%h dr=%h exp 1 0 3 5", bus.ImmediateEn, bus.UpperImmediateEn, bus.OpcodeOut, bus.DestRegOut); end
        bus.OutputReady = 1'b1;
        @(negedge clk);
        vectors++; if (bus.OutputValid !== 1'b0) begin miscompares++; $display("FAIL sext_drain got %b exp 0", bus.OutputValid); end
    endtask

    task automatic test_upper();
        bus.OutputReady = 1'b0;
        drive(1'b1, 8'h12, 1'b1, 1'b1, 1'b1, 4'h1, 4'h1, 16'h0, 16'h0);
        @(negedge clk);
        vectors++; if (bus.ImmediateOut !== 16'h1200) begin miscompares++; $display("FAIL upper_imm got %h exp 1200", bus.ImmediateOut); end
        vectors++; if (bus.UpperImmediateEn !== 1'b1) begin miscompares++; $display("FAIL upper_flag got %b exp 1", bus.UpperImmediateEn); end
        bus.OutputReady = 1'b1;
        drive(1'b1, 8'h12, 1'b1, 1'b0, 1'b0, 4'h2, 4'h2, 16'h0, 16'h0);
        @(negedge clk);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 16'h0, 16'h0);
        vectors++; if (bus.ImmediateOut !== 16'h0012) begin miscompares++; $display("FAIL zext_imm got %h exp 0012", bus.ImmediateOut); end
        vectors++; if (bus.DestRegOut !== 4'h2) begin miscompares++; $display("FAIL zext_dest got %h exp 2", bus.DestRegOut); end
        @(negedge clk);
        vectors++; if (bus.OutputValid !== 1'b0) begin miscompares++; $display("FAIL upper_drain got %b exp 0", bus.OutputValid); end
    endtask

    task automatic test_streaming();
        bus.OutputReady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            vectors++; if (bus.InputReady !== 1'b1) begin miscompares++; $display("FAIL stream_ready[%0d] got %b exp 1", i, bus.InputReady); end
            if (i > 0) begin
                vectors++; if ({bus.OutputValid, bus.DestRegOut} !== {1'b1, 4'(i - 1)}) begin
                    miscompares++; $display("FAIL stream_dest[%0d] got v=%b d=%h exp v=1 d=%h", i, bus.OutputValid, bus.DestRegOut, i - 1); end
            end
            drive(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 4'h0, 4'(i), 16'(i), 16'h0);
            @(negedge clk);
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 16'h0, 16'h0);
        vectors++; if ({bus.OutputValid, bus.DestRegOut} !== {1'b1, 4'h7}) begin
            miscompares++; $display("FAIL stream_last got v=%b d=%h exp v=1 d=7", bus.OutputValid, bus.DestRegOut); end
        @(negedge clk);
        vectors++; if (bus.OutputValid !== 1'b0) begin miscompares++; $display("FAIL stream_drain got %b exp 0", bus.OutputValid); end
    endtask

    task automatic test_stall();
        bus.OutputReady = 1'b0;
        drive(1'b1, 8'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 16'd1, 16'h0);
        @(negedge clk);
        vectors++; if (bus.InputReady !== 1'b1) begin miscompares++; $display("FAIL stall_ready_one got %b exp 1", bus.InputReady); end
        drive(1'b1, 8'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 16'd2, 16'h0);
        @(negedge clk);
        vectors++; if (bus.InputReady !== 1'b0) begin miscompares++; $display("FAIL stall_ready_full got %b exp 0", bus.InputReady); end
        drive(1'b1, 8'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 16'd3, 16'h0);
        @(negedge clk);
        vectors++; if ({bus.InputReady, bus.ADataOut} !== {1'b0, 16'd1}) begin
            miscompares++; $display("FAIL stall_hold got rdy=%b a=%h exp rdy=0 a=1", bus.InputReady, bus.ADataOut); end
        bus.OutputReady = 1'b1;
        @(negedge clk);
        vectors++; if ({bus.OutputValid, bus.ADataOut} !== {1'b1, 16'd2}) begin
            miscompares++; $display("FAIL stall_out2 got v=%b a=%h exp v=1 a=2", bus.OutputValid, bus.ADataOut); end
        @(negedge clk);
        drive(1'b0, 8'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 16'h0, 16'h0);
        vectors++; if ({bus.OutputValid, bus.ADataOut} !== {1'b1, 16'd3}) begin
            miscompares++; $display("FAIL stall_out3 got v=%b a=%h exp v=1 a=3", bus.OutputValid, bus.ADataOut); end
        @(negedge clk);
        vectors++; if (bus.OutputValid !== 1'b0) begin miscompares++; $display("FAIL stall_drain got %b exp 0", bus.OutputValid); end
    endtask

    task automatic test_flush();
        bus.OutputReady = 1'b0;
        drive(1'b1, 8'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 16'd10, 16'h0);
        @(negedge clk);
        drive(1'b1, 8'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 16'd11, 16'h0);
        @(negedge clk);
        flushEn = 1'b1;
        drive(1'b1, 8'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 16'd12, 16'h0);
        @(negedge clk);
        flushEn = 1'b0;
        vectors++; if ({bus.OutputValid, bus.InputReady} !== 2'b01) begin
            miscompares++; $display("FAIL flush_full got v=%b rdy=%b exp v=0 rdy=1", bus.OutputValid, bus.InputReady); end
        drive(1'b1, 8'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 16'd13, 16'h0);
        @(negedge clk);
        vectors++; if ({bus.OutputValid, bus.ADataOut} !== {1'b1, 16'd13}) begin
            miscompares++; $display("FAIL flush_next got v=%b a=%h exp v=1 a=13", bus.OutputValid, bus.ADataOut); end
        flushEn = 1'b1;
        drive(1'b1, 8'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 16'd14, 16'h0);
        @(negedge clk);
        flushEn = 1'b0;
        drive(1'b0, 8'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 16'h0, 16'h0);
        vectors++; if (bus.OutputValid !== 1'b0) begin miscompares++; $display("FAIL flush_discard got %b exp 0", bus.OutputValid); end
        @(negedge clk);
        vectors++; if (bus.OutputValid !== 1'b0) begin miscompares++; $display("FAIL flush_discard_late got %b exp 0", bus.OutputValid); end
    endtask

    task automatic test_clear();
        bus.OutputReady = 1'b0;
        drive(1'b1, 8'h81, 1'b1, 1'b1, 1'b1, 4'hA, 4'hB, 16'd20, 16'hBEEF);
        @(negedge clk);
        drive(1'b1, 8'h81, 1'b1, 1'b0, 1'b1, 4'hC, 4'hD, 16'd21, 16'hCAFE);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        vectors++; if ({bus.OutputValid, bus.InputReady} !== 2'b00) begin
            miscompares++; $display("FAIL clear_hs got v=%b rdy=%b exp 0 0", bus.OutputValid, bus.InputReady); end
        vectors++; if ({bus.ImmediateOut, bus.ADataOut, bus.BDataOut, bus.OpcodeOut, bus.DestRegOut, bus.ImmediateEn, bus.UpperImmediateEn} !== 58'd0) begin
            miscompares++; $display("FAIL clear_payload got imm=%h a=%h b=%h exp all zero", bus.ImmediateOut, bus.ADataOut, bus.BDataOut); end
        clear = 1'b0;
        drive(1'b0, 8'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 16'h0, 16'h0);
        bus.OutputReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++; if ({bus.OutputValid, bus.InputReady} !== 2'b01) begin
                miscompares++; $display("FAIL clear_stale[%0d] got v=%b rdy=%b exp v=0 rdy=1", i, bus.OutputValid, bus.InputReady); end
        end
    endtask

    task automatic test_random();
        exp_t e;
        logic expReady, expValid, v, up, se, ie;
        logic [7:0] imm;
        logic [3:0] opc, dest;
        logic [15:0] a, b;
        model.delete();
        for (int cyc = 0; cyc < 500; cyc++) begin
            @(negedge clk);
            expReady = (model.size() < 2);
            expValid = (model.size() > 0);
            vectors++; if (bus.InputReady !== expReady) begin miscompares++; $display("FAIL rand_ready[%0d] got %b exp %b", cyc, bus.InputReady, expReady); end
            vectors++; if (bus.OutputValid !== expValid) begin miscompares++; $display("FAIL rand_valid[%0d] got %b exp %b", cyc, bus.OutputValid, expValid); end
            if (expValid) begin
                e = model[0];
                vectors++; if (bus.ImmediateOut !== e.imm) begin miscompares++; $display("FAIL rand_imm[%0d] got %h exp %h", cyc, bus.ImmediateOut, e.imm); end
                vectors++; if ({bus.ImmediateEn, bus.UpperImmediateEn, bus.OpcodeOut, bus.DestRegOut} !== {e.immEn, e.upper, e.opc, e.dest}) begin
                    miscompares++; $display("FAIL rand_ctrl[%0d] got %b%b %h %h exp %b%b %h %h", cyc, bus.ImmediateEn, bus.UpperImmediateEn,
                                            bus.OpcodeOut, bus.DestRegOut, e.immEn, e.upper, e.opc, e.dest); end
                vectors++; if ({bus.ADataOut, bus.BDataOut} !== {e.a, e.b}) begin
                    miscompares++; $display("FAIL rand_ops[%0d] got %h %h exp %h %h", cyc, bus.ADataOut, bus.BDataOut, e.a, e.b); end
            end
            v = ($urandom_range(0, 3) != 0);
            imm = 8'($urandom); ie = 1'($urandom); up = 1'($urandom); se = 1'($urandom);
            opc = 4'($urandom); dest = 4'($urandom); a = 16'($urandom); b = 16'($urandom);
            drive(v, imm, ie, up, se, opc, dest, a, b);
            bus.OutputReady = ($urandom_range(0, 2) != 0);
            flushEn = ($urandom_range(0, 24) == 0);
            if (flushEn) begin
                model.delete();
            end else begin
                if (expValid && bus.OutputReady) void'(model.pop_front());
                if (v && expReady) begin
                    e.immEn = ie; e.upper = up; e.imm = refImm(imm, up, se);
                    e.opc = opc; e.dest = dest; e.a = a; e.b = b;
                    model.push_back(e);
                end
            end
        end
        @(negedge clk);
        flushEn = 1'b0;
        drive(1'b0, 8'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 16'h0, 16'h0);
    endtask

    initial begin
        clk = 1'b0;
        clear = 1'b1;
        flushEn = 1'b0;
        vectors = 0;
        miscompares = 0;
        bus.OutputReady = 1'b0;
        drive(1'b0, 8'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 16'h0, 16'h0);
        test_reset();
        test_sign_extend();
        test_upper();
        test_streaming();
        test_stall();
        test_flush();
        test_clear();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
